// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the fifo_reader drain adapter: buffer-depth legality
// and the pointer/occupancy widths derived from BUF_DEPTH.
package fifo_reader_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_BUF_DEPTH  = 2;
    localparam int COUNT_WIDTH        = 16;

    function automatic bit depth_is_legal(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so a completely full buffer (occ == depth) is representable.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_reader_skid_buf.sv
// Circular output buffer for fifo_reader: storage, read/write pointers and
// occupancy. Full and empty both have equal pointers and are told apart by occ.
module reader_skid_buf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH  = DEFAULT_BUF_DEPTH,
    localparam int PTR_W     = ptr_width(BUF_DEPTH),
    localparam int OCC_W     = occ_width(BUF_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [OCC_W-1:0]      occ_o
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  wr_fire;

    // A flush wins over both a capture and a pop on the same edge.
    assign wr_fire = wr_en_i & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            occ_d = occ_q + OCC_W'(wr_en_i) - OCC_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Entries are cleared on reset so the stream data reads as zero afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side drain adapter: pops the dual-clock FIFO under credit control and
// re-presents words as a valid/ready stream. FIFO_READER_COUNT_EN adds Count_out.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH  = DEFAULT_BUF_DEPTH
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   FifoEmpty_in,
    output logic                   FifoReadEn_out,
    input  logic [DATA_WIDTH-1:0]  FifoData_in,
    input  logic                   Flush_in,
    output logic [DATA_WIDTH-1:0]  Data_out,
    output logic                   Valid_out,
    input  logic                   Ready_in
`ifdef FIFO_READER_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] Count_out
`endif
);

    localparam int OCC_W  = occ_width(BUF_DEPTH);
    localparam int CRED_W = OCC_W + 1;

    if (!depth_is_legal(BUF_DEPTH)) begin : g_bad_depth
        $error("fifo_reader: BUF_DEPTH must be a power of two and at least 2");
    end

    logic              pend_q, pend_d;
    logic [OCC_W-1:0]  occ_w;
    logic              pop;
    logic [CRED_W-1:0] credit;
    logic              room;

    assign pop = Valid_out & Ready_in;

    // Occupancy the buffer will hold after this edge; a pop frees its slot
    // in the same cycle, which is what sustains one word per cycle.
    always_comb begin
        credit = CRED_W'(occ_w) + CRED_W'(pend_q) - CRED_W'(pop);
        room   = credit < CRED_W'(BUF_DEPTH);
    end

    assign FifoReadEn_out = Reset_n & ~Flush_in & ~FifoEmpty_in & room;
    assign pend_d         = FifoReadEn_out;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    reader_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk_i     (Clk),
        .rst_ni    (Reset_n),
        .flush_i   (Flush_in),
        .wr_en_i   (pend_q),
        .wr_data_i (FifoData_in),
        .pop_i     (pop),
        .head_o    (Data_out),
        .occ_o     (occ_w)
    );

    assign Valid_out = (occ_w != '0);

`ifdef FIFO_READER_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    // Flush does not clear the count, and a pop on the flush edge is discarded.
    assign count_d = (pop && !Flush_in) ? count_q + COUNT_WIDTH'(1) : count_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Count_out = count_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed self-checking bench for fifo_reader with a registered-read FIFO model.
// The counter steps run only when FIFO_READER_COUNT_EN is defined.
module tb_fifo_reader;

    logic        Clk;
    logic        Reset_n;
    logic        FifoEmpty_in;
    logic        FifoReadEn_out;
    logic [7:0]  FifoData_in;
    logic        Flush_in;
    logic [7:0]  Data_out;
    logic        Valid_out;
    logic        Ready_in;
`ifdef FIFO_READER_COUNT_EN
    logic [15:0] Count_out;
`endif

    int checks = 0;
    int errors = 0;
    int creditViolations = 0;
    int base;

    logic [7:0] fifoMem [1024];
    int wrIdx = 0;
    int rdIdx = 0;

    fifo_reader #(.DATA_WIDTH(8), .BUF_DEPTH(2)) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .FifoEmpty_in   (FifoEmpty_in),
        .FifoReadEn_out (FifoReadEn_out),
        .FifoData_in    (FifoData_in),
        .Flush_in       (Flush_in),
        .Data_out       (Data_out),
        .Valid_out      (Valid_out),
        .Ready_in       (Ready_in)
`ifdef FIFO_READER_COUNT_EN
        ,
        .Count_out      (Count_out)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // FIFO read port model: registered data, zero on a read while empty.
    assign FifoEmpty_in = (wrIdx == rdIdx);
    always @(posedge Clk) begin
        if (FifoReadEn_out) begin
            if (wrIdx != rdIdx) begin
                FifoData_in <= fifoMem[rdIdx % 1024];
                rdIdx       <= rdIdx + 1;
            end else begin
                FifoData_in <= 8'h00;
            end
        end
    end

    always @(negedge Clk) begin
        if (Reset_n && (int'(dut.occ_w) + int'(dut.pend_q) > 2)) begin
            creditViolations <= creditViolations + 1;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushWord(input logic [7:0] d);
        fifoMem[wrIdx % 1024] = d;
        wrIdx = wrIdx + 1;
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    initial begin
        Reset_n     = 1'b0;
        Ready_in    = 1'b0;
        Flush_in    = 1'b0;
        FifoData_in = 8'h00;
        #1;
        checkVal("reset_valid", Valid_out, 0);
        checkVal("reset_rden", FifoReadEn_out, 0);
        checkVal("reset_data", Data_out, 0);
`ifdef FIFO_READER_COUNT_EN
        checkVal("reset_count", Count_out, 0);
`endif
        tick();
        Reset_n = 1'b1;
        tick();

        // Single word: read in N, valid exactly in N+2 for one cycle.
        Ready_in = 1'b1;
        pushWord(8'hA5);
        #1;
        checkVal("single_rden_n", FifoReadEn_out, 1);
        checkVal("single_valid_n", Valid_out, 0);
        tick();
        checkVal("single_rden_n1", FifoReadEn_out, 0);
        checkVal("single_valid_n1", Valid_out, 0);
        tick();
        checkVal("single_valid_n2", Valid_out, 1);
        checkVal("single_data_n2", Data_out, 32'hA5);
        tick();
        checkVal("single_valid_n3", Valid_out, 0);

        // Streaming: 16 back-to-back words.
        for (int i = 0; i < 16; i++) pushWord(8'(i));
        #1;
        checkVal("stream_rden", FifoReadEn_out, 1);
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            checkVal($sformatf("stream_valid_%0d", i), Valid_out, 1);
            checkVal($sformatf("stream_data_%0d", i), Data_out, i);
            tick();
        end
        checkVal("stream_valid_end", Valid_out, 0);
        checkVal("stream_rden_end", FifoReadEn_out, 0);

        // Back-pressure: only two words accepted while Ready_in is low.
        Ready_in = 1'b0;
        base = rdIdx;
        for (int i = 0; i < 4; i++) pushWord(8'h20 + 8'(i));
        #1;
        checkVal("bp_rden_first", FifoReadEn_out, 1);
        repeat (4) tick();
        checkVal("bp_pops", rdIdx - base, 2);
        checkVal("bp_rden_held", FifoReadEn_out, 0);
        checkVal("bp_valid", Valid_out, 1);
        checkVal("bp_data_hold", Data_out, 32'h20);
        Ready_in = 1'b1;
        #1;
        checkVal("bp_rden_resume", FifoReadEn_out, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            checkVal($sformatf("bp_valid_%0d", i), Valid_out, 1);
            checkVal($sformatf("bp_data_%0d", i), Data_out, 32'h20 + i);
        end
        tick();
        checkVal("bp_valid_end", Valid_out, 0);

        // Empty flag rises while the only word is in flight.
        base = rdIdx;
        pushWord(8'h30);
        tick();
        checkVal("empty_flag", FifoEmpty_in, 1);
        checkVal("empty_rden", FifoReadEn_out, 0);
        tick();
        checkVal("empty_valid", Valid_out, 1);
        checkVal("empty_data", Data_out, 32'h30);
        tick();
        checkVal("empty_valid_end", Valid_out, 0);
        checkVal("empty_reads", rdIdx - base, 1);

        // Flush with one word buffered and one in flight.
        Ready_in = 1'b0;
        base = rdIdx;
        pushWord(8'h40);
        pushWord(8'h41);
        pushWord(8'h42);
        tick();
        tick();
        checkVal("flush_pre_valid", Valid_out, 1);
        checkVal("flush_pre_data", Data_out, 32'h40);
        Flush_in = 1'b1;
        #1;
        checkVal("flush_rden_low", FifoReadEn_out, 0);
        tick();
        checkVal("flush_valid_low", Valid_out, 0);
        Flush_in = 1'b0;
        Ready_in = 1'b1;
        #1;
        checkVal("flush_rden_after", FifoReadEn_out, 1);
        tick();
        checkVal("flush_valid_gap", Valid_out, 0);
        tick();
        checkVal("flush_next_valid", Valid_out, 1);
        checkVal("flush_next_data", Data_out, 32'h42);
        tick();
        checkVal("flush_valid_end", Valid_out, 0);
        checkVal("flush_reads", rdIdx - base, 3);
`ifdef FIFO_READER_COUNT_EN
        checkVal("flush_count", Count_out, 23);
`endif

        // Asynchronous reset mid-stream after three deliveries.
        for (int i = 0; i < 5; i++) pushWord(8'h50 + 8'(i));
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal($sformatf("rst_data_%0d", i), Data_out, 32'h50 + i);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        checkVal("rst_valid", Valid_out, 0);
        checkVal("rst_rden", FifoReadEn_out, 0);
        checkVal("rst_data", Data_out, 0);
`ifdef FIFO_READER_COUNT_EN
        checkVal("rst_count", Count_out, 0);
`endif
        tick();
        Reset_n = 1'b1;
        #1;
        checkVal("rst_rden_after", FifoReadEn_out, 1);
        tick();
        tick();
        checkVal("rst_next_valid", Valid_out, 1);
        checkVal("rst_next_data", Data_out, 32'h54);
        tick();
        checkVal("rst_valid_end", Valid_out, 0);
`ifdef FIFO_READER_COUNT_EN
        checkVal("rst_count_after", Count_out, 1);

        // Counter wrap: 65537 pops from reset leave the count at 1.
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        wrIdx = wrIdx + 65537;
        repeat (65537 + 6) tick();
        checkVal("wrap_valid", Valid_out, 0);
        checkVal("wrap_drained", wrIdx - rdIdx, 0);
        checkVal("wrap_count", Count_out, 1);
`endif

        checkVal("credit_invariant", creditViolations, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
